// File: rtl/svm_mem_mngr_mc.sv
// Multi-channel SVM memory manager: wrapping per-region read pointers, split DMA bursts,
// channel-tagged responses and the ROM read-data FIFO. Optional DMA watchdog: SVM_MEM_MNGR_TIMEOUT_EN.
module svm_mem_mngr_mc #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 16,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 1024,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_done,
  input  logic [NUM_CH*ADDR_W-1:0] cfg_base,
  input  logic [NUM_CH*LEN_W-1:0]  cfg_len,
  input  logic                     cmd_vld,
  output logic                     cmd_rdy,
  input  logic [1:0]               cmd_op,
  input  logic [CH_W-1:0]          cmd_ch,
  input  logic [LEN_W-1:0]         cmd_len,
  output logic                     dma_req_vld,
  input  logic                     dma_req_rdy,
  output logic [ADDR_W-1:0]        dma_addr,
  output logic [ADDR_W-1:0]        dma_bytes,
  input  logic                     dma_done,
  output logic                     resp_vld,
  input  logic                     resp_rdy,
  output logic [2:0]               resp_code,
  output logic [CH_W-1:0]          resp_ch,
  output logic                     busy,
  input  logic                     fifo_push,
  input  logic [DATA_W-1:0]        fifo_din,
  input  logic                     fifo_pop,
  output logic [DATA_W-1:0]        fifo_dout,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [LVL_W-1:0]         fifo_level,
  output logic                     fifo_ovf
);
  localparam int            PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

  localparam logic [1:0] OP_LOAD = 2'd0, OP_SKIP = 2'd1, OP_REWIND = 2'd2;
  localparam logic [2:0] RC_LOAD = 3'd0, RC_SKIP = 3'd1, RC_REWIND = 3'd2, RC_WR = 3'd3,
                         RC_TIMEOUT = 3'd6, RC_ERR = 3'd7;

  typedef enum logic [2:0] {IDLE, WAIT_CMD, DMA_REQ, DMA_WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q   [NUM_CH], base_d   [NUM_CH];
  logic [LEN_W-1:0]  lenReg_q [NUM_CH], lenReg_d [NUM_CH];
  logic [LEN_W-1:0]  off_q    [NUM_CH], off_d    [NUM_CH];
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [2:0]        code_q, code_d;

  logic              chValid, cmdErr, timeout;
  logic [CH_W-1:0]   cmdIdx;
  logic [LEN_W-1:0]  avail, seg, skipOff, doneOff;

  // Offsets never exceed the region length, so a single conditional subtract wraps them.
  function automatic logic [LEN_W-1:0] wrapAdd(input logic [LEN_W-1:0] a, b, lim);
    logic [LEN_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, lim}) sum = sum - {1'b0, lim};
    return sum[LEN_W-1:0];
  endfunction

  assign chValid = ({1'b0, cmd_ch} < NUM_CH_V);
  assign cmdIdx  = chValid ? cmd_ch : '0;
  assign cmdErr  = !chValid || (cmd_len > lenReg_q[cmdIdx]) ||
                   (((cmd_op == OP_LOAD) || (cmd_op == OP_SKIP)) && (cmd_len == '0));
  assign avail   = lenReg_q[ch_q] - off_q[ch_q];
  assign seg     = (rem_q < avail) ? rem_q : avail;
  assign skipOff = wrapAdd(off_q[cmdIdx], cmd_len, lenReg_q[cmdIdx]);
  assign doneOff = wrapAdd(off_q[ch_q], seg, lenReg_q[ch_q]);

`ifdef SVM_MEM_MNGR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] toCnt_q, toCnt_d;

  assign timeout = (state_q == DMA_WAIT) && !dma_done && (toCnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    toCnt_d = toCnt_q;
    if (state_q == DMA_REQ)       toCnt_d = '0;
    else if (state_q == DMA_WAIT) toCnt_d = toCnt_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) toCnt_q <= '0;
    else        toCnt_q <= toCnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cfg_done) state_d = WAIT_CMD;
      WAIT_CMD: if (cmd_vld) state_d = (cmdErr || (cmd_op != OP_LOAD)) ? RESP : DMA_REQ;
      DMA_REQ:  if (dma_req_rdy) state_d = DMA_WAIT;
      DMA_WAIT: begin
        if (dma_done)     state_d = (rem_q != seg) ? DMA_REQ : RESP;
        else if (timeout) state_d = RESP;
      end
      RESP:     if (resp_rdy) state_d = WAIT_CMD;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_rdy     = 1'b0;
    dma_req_vld = 1'b0;
    dma_addr    = '0;
    dma_bytes   = '0;
    resp_vld    = 1'b0;
    resp_code   = '0;
    resp_ch     = '0;
    busy        = (state_q != IDLE) && (state_q != WAIT_CMD);
    case (state_q)
      WAIT_CMD: cmd_rdy = 1'b1;
      DMA_REQ: begin
        dma_req_vld = 1'b1;
        dma_addr    = base_q[ch_q] + (ADDR_W'(off_q[ch_q]) << 2);
        dma_bytes   = ADDR_W'(seg) << 2;
      end
      RESP: begin
        resp_vld  = 1'b1;
        resp_code = code_q;
        resp_ch   = ch_q;
      end
      default: ;
    endcase
  end

  // Region table, per-channel offsets and the in-flight command.
  always_comb begin
    base_d   = base_q;
    lenReg_d = lenReg_q;
    off_d    = off_q;
    ch_d     = ch_q;
    rem_d    = rem_q;
    code_d   = code_q;
    case (state_q)
      IDLE: if (cfg_done) begin
        for (int c = 0; c < NUM_CH; c++) begin
          base_d[c]   = cfg_base[c*ADDR_W +: ADDR_W];
          lenReg_d[c] = cfg_len[c*LEN_W +: LEN_W];
          off_d[c]    = '0;
        end
      end
      WAIT_CMD: if (cmd_vld) begin
        ch_d  = cmd_ch;
        rem_d = cmd_len;
        if (cmdErr) code_d = RC_ERR;
        else begin
          case (cmd_op)
            OP_LOAD:   code_d = RC_LOAD;
            OP_SKIP:   begin off_d[cmdIdx] = skipOff; code_d = RC_SKIP; end
            OP_REWIND: begin off_d[cmdIdx] = '0;      code_d = RC_REWIND; end
            default:   code_d = RC_WR;
          endcase
        end
      end
      DMA_WAIT: begin
        if (dma_done) begin
          off_d[ch_q] = doneOff;
          rem_d       = rem_q - seg;
          code_d      = RC_LOAD;
        end else if (timeout) begin
          code_d = RC_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q   <= '{default: '0};
      lenReg_q <= '{default: '0};
      off_q    <= '{default: '0};
      ch_q     <= '0;
      rem_q    <= '0;
      code_q   <= '0;
    end else begin
      base_q   <= base_d;
      lenReg_q <= lenReg_d;
      off_q    <= off_d;
      ch_q     <= ch_d;
      rem_q    <= rem_d;
      code_q   <= code_d;
    end
  end

  // ROM read-data FIFO; a pop frees the slot a same-cycle push needs when full.
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
  logic [LVL_W-1:0]  level_q;
  logic              ovf_q, doPush, doPop;

  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign fifo_level = level_q;
  assign fifo_ovf   = ovf_q;
  assign fifo_dout  = fifo_empty ? '0 : mem[rdPtr_q];
  assign doPop      = fifo_pop && !fifo_empty;
  assign doPush     = fifo_push && (!fifo_full || doPop);

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= fifo_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: ;
      endcase
      if (fifo_push && fifo_full && !doPop) ovf_q <= 1'b1;
    end
  end
endmodule
